lut_k_cfg: RTL and testbench

Parametrised, clocked successor to the single 4-input LUT cell. Holds `CHANNELS` independent K-input LUTs whose truth tables are loaded from a serial bitstream through a valid/ready handshake under a small configuration FSM. LUT outputs are gated off until a complete bitstream has been accepted. The block sits between the configuration loader and the user logic fabric of the tile.

---
 rtl/lut_cfg_pkg.sv | 18 +
 rtl/lut_k_cell.sv | 39 +++
 rtl/lut_k_cfg.sv | 118 +++++++++++
 tb/tb_lut_k_cfg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// rtl/lut_cfg_pkg.sv - shared FSM state type and parameter limits for lut_k_cfg
package lut_cfg_pkg;

    localparam int LUT_K_MAX  = 6;
    localparam int LUT_CH_MAX = 16;

    typedef enum logic [1:0] {
        LUT_UNCFG  = 2'd0,
        LUT_LOAD   = 2'd1,
        LUT_ACTIVE = 2'd2
    } lut_state_e;

    // Bit-counter width for a bitstream of the given length, never below 1.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/lut_k_cell.sv
// rtl/lut_k_cell.sv - one channel's 2**K truth-table bits with write port and read mux
module lut_k_cell
    import lut_cfg_pkg::*;
#(
    parameter int K = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_we,
    input  logic [K-1:0] i_widx,
    input  logic         i_wdata,
    input  logic [K-1:0] i_raddr,
    output logic         o_rdata
);

    localparam int DEPTH = 2 ** K;

    logic [DEPTH-1:0] tbl_q, tbl_d;

    // Single-bit write into the addressed table entry.
    always_comb begin
        tbl_d = tbl_q;
        if (i_we) begin
            tbl_d[i_widx] = i_wdata;
        end
    end

    // Table storage; reset clears every entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tbl_q <= '0;
        end else begin
            tbl_q <= tbl_d;
        end
    end

    assign o_rdata = tbl_q[i_raddr];

endmodule

// File: rtl/lut_k_cfg.sv
// rtl/lut_k_cfg.sv - CHANNELS K-input LUTs loaded serially; LUT_REG_OUT_EN registers o_lut_out
module lut_k_cfg
    import lut_cfg_pkg::*;
#(
    parameter int K        = 4,
    parameter int CHANNELS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cfg_start,
    input  logic                  i_cfg_valid,
    input  logic                  i_cfg_data,
    output logic                  o_cfg_ready,
    output logic                  o_cfg_busy,
    output logic                  o_cfg_done,
    input  logic [CHANNELS*K-1:0] i_lut_in,
    output logic [CHANNELS-1:0]   o_lut_out
);

    localparam int DEPTH = 2 ** K;
    localparam int TOTAL = CHANNELS * DEPTH;
    localparam int CNT_W = cnt_width(TOTAL);

    if (K < 1 || K > LUT_K_MAX) begin : g_bad_k
        $error("lut_k_cfg: K out of range");
    end
    if (CHANNELS < 1 || CHANNELS > LUT_CH_MAX) begin : g_bad_ch
        $error("lut_k_cfg: CHANNELS out of range");
    end

    lut_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, busy_q, done_q;
    logic             accept;
    logic             last_beat;
    logic [CHANNELS-1:0] lut_raw;

    // Start always wins over a beat in the same cycle.
    assign accept    = i_cfg_valid & ready_q & ~i_cfg_start;
    assign last_beat = (cnt_q == CNT_W'(TOTAL - 1));

    // Next state and bit counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_cfg_start) begin
            state_d = LUT_LOAD;
            cnt_d   = '0;
        end else if (accept) begin
            if (last_beat) begin
                state_d = LUT_ACTIVE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Configuration FSM with status outputs decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= LUT_UNCFG;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == LUT_LOAD);
            busy_q  <= (state_d == LUT_LOAD);
            done_q  <= (state_d == LUT_ACTIVE);
        end
    end

    assign o_cfg_ready = ready_q;
    assign o_cfg_busy  = busy_q;
    assign o_cfg_done  = done_q;

    // Beat b goes to channel b / DEPTH, entry b % DEPTH.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic we;
        assign we = accept && ((cnt_q >> K) == CNT_W'(c));

        lut_k_cell #(.K(K)) u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_we    (we),
            .i_widx  (cnt_q[K-1:0]),
            .i_wdata (i_cfg_data),
            .i_raddr (i_lut_in[c*K +: K]),
            .o_rdata (lut_raw[c])
        );
    end

`ifdef LUT_REG_OUT_EN
    logic [CHANNELS-1:0] out_q, out_d;

    // Output flop holds 0 whenever the configuration is not live.
    always_comb begin
        out_d = (state_q == LUT_ACTIVE) ? lut_raw : '0;
    end

    // Registered LUT outputs, one cycle behind i_lut_in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign o_lut_out = out_q;
`else
    assign o_lut_out = done_q ? lut_raw : '0;
`endif

endmodule

// File: tb/tb_lut_k_cfg.sv
// tb/tb_lut_k_cfg.sv - self-checking bench for lut_k_cfg (K=4, CHANNELS=2)
module tb_lut_k_cfg;

    localparam int K     = 4;
    localparam int CH    = 2;
    localparam int DEPTH = 16;
    localparam int TOTAL = CH * DEPTH;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_cfg_start;
    logic          i_cfg_valid;
    logic          i_cfg_data;
    logic          o_cfg_ready;
    logic          o_cfg_busy;
    logic          o_cfg_done;
    logic [CH*K-1:0] i_lut_in;
    logic [CH-1:0] o_lut_out;

    int n_checks = 0;
    int n_errors = 0;

    lut_k_cfg #(.K(K), .CHANNELS(CH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cfg_start (i_cfg_start),
        .i_cfg_valid (i_cfg_valid),
        .i_cfg_data  (i_cfg_data),
        .o_cfg_ready (o_cfg_ready),
        .o_cfg_busy  (o_cfg_busy),
        .o_cfg_done  (o_cfg_done),
        .i_lut_in    (i_lut_in),
        .o_lut_out   (o_lut_out)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: configured flag, bits accepted since the last start, table contents.
    logic [DEPTH-1:0] mtbl [CH];
    bit               m_loading;
    bit               m_live;
    int               m_beats;
    logic [CH-1:0]    exp_reg;

    typedef struct packed {
        logic [CH*K-1:0] lin;
        logic [CH-1:0]   exp;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CH-1:0] model_comb();
        logic [CH-1:0] r;
        r = '0;
        if (m_live) begin
            for (int c = 0; c < CH; c++) r[c] = mtbl[c][i_lut_in[c*K +: K]];
        end
        return r;
    endfunction

    function automatic logic [CH-1:0] model_out();
`ifdef LUT_REG_OUT_EN
        return exp_reg;
`else
        return model_comb();
`endif
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) mtbl[c] = '0;
        m_loading = 0;
        m_live    = 0;
        m_beats   = 0;
        exp_reg   = '0;
    endtask

    // One clock: drive, advance the model across the edge, compare at the falling edge.
    task automatic step(input logic s, input logic v, input logic d);
        logic [CH-1:0] comb_pre;
        i_cfg_start = s;
        i_cfg_valid = v;
        i_cfg_data  = d;
        comb_pre = model_comb();
        @(posedge i_clk);
        exp_reg = comb_pre;
        if (s) begin
            m_loading = 1;
            m_live    = 0;
            m_beats   = 0;
        end else if (v && m_loading) begin
            mtbl[m_beats / DEPTH][m_beats % DEPTH] = d;
            m_beats++;
            if (m_beats == TOTAL) begin
                m_loading = 0;
                m_live    = 1;
            end
        end
        @(negedge i_clk);
        i_cfg_start = 1'b0;
        i_cfg_valid = 1'b0;
        check("ready", 32'(o_cfg_ready), 32'(m_loading));
        check("busy",  32'(o_cfg_busy),  32'(m_loading));
        check("done",  32'(o_cfg_done),  32'(m_live));
        check("lut_out", 32'(o_lut_out), 32'(model_out()));
    endtask

    task automatic load_words(input logic [15:0] w0, input logic [15:0] w1);
        logic [31:0] bits;
        bits = {w1, w0};
        for (int b = 0; b < TOTAL; b++) begin
            if ($urandom_range(0, 2) == 0) begin
                i_lut_in = 8'($urandom);
                step(1'b0, 1'b0, 1'($urandom));
            end
            i_lut_in = 8'($urandom);
            step(1'b0, 1'b1, bits[b]);
        end
    endtask

    task automatic random_reads(input int n);
        for (int i = 0; i < n; i++) begin
            i_lut_in = 8'($urandom);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{lin: 8'h1F, exp: 2'b11};
        vecs[1] = '{lin: 8'h3E, exp: 2'b00};
        vecs[2] = '{lin: 8'h3F, exp: 2'b01};
        vecs[3] = '{lin: 8'h1E, exp: 2'b10};
        vecs[4] = '{lin: 8'h70, exp: 2'b10};
        vecs[5] = '{lin: 8'hFF, exp: 2'b01};

        i_rst_n     = 1'b0;
        i_cfg_start = 1'b0;
        i_cfg_valid = 1'b0;
        i_cfg_data  = 1'b0;
        i_lut_in    = 8'hFF;
        model_reset();
        #2;
        check("rst_ready", 32'(o_cfg_ready), 32'd0);
        check("rst_busy",  32'(o_cfg_busy),  32'd0);
        check("rst_done",  32'(o_cfg_done),  32'd0);
        check("rst_out",   32'(o_lut_out),   32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        random_reads(4);

        // Basic load: AND4 on ch0, parity on ch1.
        step(1'b1, 1'b0, 1'b0);
        load_words(16'h8000, 16'h6996);
        check("basic_done", 32'(o_cfg_done), 32'd1);
        for (int i = 0; i < 6; i++) begin
            i_lut_in = vecs[i].lin;
            step(1'b0, 1'b0, 1'b0);
            check("vec_out", 32'(o_lut_out), 32'(vecs[i].exp));
        end
        random_reads(20);

        // Input edge E->F on ch0: same-cycle without the register, one edge later with it.
        i_lut_in = 8'h0E;
        step(1'b0, 1'b0, 1'b0);
        i_lut_in = 8'h0F;
        #1;
`ifdef LUT_REG_OUT_EN
        check("edge_pre", 32'(o_lut_out[0]), 32'd0);
`else
        check("edge_pre", 32'(o_lut_out[0]), 32'd1);
`endif
        step(1'b0, 1'b0, 1'b0);
        check("edge_post", 32'(o_lut_out[0]), 32'd1);

        // Restart mid-load with valid high on the restart cycle.
        step(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 10; b++) step(1'b0, 1'b1, 1'($urandom));
        step(1'b1, 1'b1, 1'b1);
        load_words(16'($urandom), 16'($urandom));
        check("restart_done", 32'(o_cfg_done), 32'd1);
        random_reads(10);

        // Reconfigure from ACTIVE: NOR4 on ch0.
        step(1'b1, 1'b0, 1'b0);
        load_words(16'h0001, 16'($urandom));
        i_lut_in = 8'h00;
        step(1'b0, 1'b0, 1'b0);
        check("nor_0", 32'(o_lut_out[0]), 32'd1);
        i_lut_in = 8'h01;
        step(1'b0, 1'b0, 1'b0);
        check("nor_1", 32'(o_lut_out[0]), 32'd0);

        // Reset in the middle of a load.
        step(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 20; b++) step(1'b0, 1'b1, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(o_cfg_ready), 32'd0);
        check("mid_rst_busy",  32'(o_cfg_busy),  32'd0);
        check("mid_rst_done",  32'(o_cfg_done),  32'd0);
        check("mid_rst_out",   32'(o_lut_out),   32'd0);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        random_reads(5);
        step(1'b1, 1'b0, 1'b0);
        load_words(16'h8000, 16'h6996);
        check("reload_done", 32'(o_cfg_done), 32'd1);
        for (int i = 0; i < 6; i++) begin
            i_lut_in = vecs[i].lin;
            step(1'b0, 1'b0, 1'b0);
            check("vec2_out", 32'(o_lut_out), 32'(vecs[i].exp));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
